arch_event_gen: RTL

- Producer side of the ArchEvent difftest channel. Captures trap events (interrupts, exceptions, NMIs) from the CSR/trap unit at commit.
- Encodes each event into the ArchEvent bundle and buffers it in a small FIFO. Presents events in order to a downstream consumer (difftest sink or batching stage) with valid/ready backpressure.
- Sits between the trap unit and the difftest export path, one instance per core.

---
 rtl/arch_event_gen_pkg.sv | 55 +++++
 rtl/arch_event_gen_if.sv | 29 ++
 rtl/arch_event_gen_fifo.sv | 73 +++++++
 rtl/arch_event_gen.sv | 91 +++++++++
 4 files changed

// File: rtl/arch_event_gen_pkg.sv
// Shared types, constants and the trap-to-ArchEvent encoder for the difftest producer.
package arch_event_pkg;

  localparam int unsigned ARCH_EVENT_VALID_BIT = 31;
  localparam int unsigned ARCH_EVENT_CAUSE_W   = 6;
  localparam int unsigned ARCH_EVENT_SEQ_W     = 16;

  typedef struct packed {
    logic [31:0]                 interrupt;
    logic [31:0]                 exception;
    logic [63:0]                 pc;
    logic [31:0]                 inst;
    logic                        hasNmi;
    logic                        hvictlInject;
    logic                        irToHs;
    logic                        irToVs;
    logic [7:0]                  coreid;
    logic [ARCH_EVENT_SEQ_W-1:0] seq;
  } arch_event_t;

  // Bit 31 flags the populated cause field, so exception cause 0 stays visible.
  function automatic arch_event_t encodeEvent(
    input logic                        isInterrupt,
    input logic [30:0]                 cause,
    input logic [63:0]                 pc,
    input logic [31:0]                 inst,
    input logic                        hasNmi,
    input logic                        hvictlInject,
    input logic                        irToHs,
    input logic                        irToVs,
    input logic [7:0]                  coreid,
    input logic [ARCH_EVENT_SEQ_W-1:0] seq
  );
    arch_event_t ev;
    logic [31:0] field;
    field = 32'(cause);
    field[ARCH_EVENT_VALID_BIT] = 1'b1;
    ev = '0;
    if (isInterrupt) begin
      ev.interrupt = field;
    end else begin
      ev.exception = field;
    end
    ev.pc           = pc;
    ev.inst         = inst;
    ev.hasNmi       = hasNmi;
    ev.hvictlInject = hvictlInject;
    ev.irToHs       = irToHs;
    ev.irToVs       = irToVs;
    ev.coreid       = coreid;
    ev.seq          = seq;
    return ev;
  endfunction

endpackage

// File: rtl/arch_event_gen_if.sv
// ArchEvent output channel: head event fields with valid/ready handshake.
interface arch_event_gen_if #(
  parameter int unsigned SEQ_W = 16
) ();
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_interrupt;
  logic [31:0]      out_exception;
  logic [63:0]      out_exception_pc;
  logic [31:0]      out_exception_inst;
  logic             out_has_nmi;
  logic             out_hvictl_inject;
  logic             out_ir_to_hs;
  logic             out_ir_to_vs;
  logic [7:0]       out_coreid;
  logic [SEQ_W-1:0] out_seq;

  modport master (
    output out_valid, out_interrupt, out_exception, out_exception_pc, out_exception_inst,
           out_has_nmi, out_hvictl_inject, out_ir_to_hs, out_ir_to_vs, out_coreid, out_seq,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_interrupt, out_exception, out_exception_pc, out_exception_inst,
           out_has_nmi, out_hvictl_inject, out_ir_to_hs, out_ir_to_vs, out_coreid, out_seq,
    output out_ready
  );
endinterface

// File: rtl/arch_event_gen_fifo.sv
// Synchronous FIFO of ArchEvent entries with flush and same-cycle push/pop.
module arch_event_fifo
  import arch_event_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush,
  input  logic        push,
  input  arch_event_t pushData,
  input  logic        pop,
  output arch_event_t popData,
  output logic        empty,
  output logic        pushAccepted
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  arch_event_t   mem [DEPTH];
  logic [AW-1:0] rdPtr;
  logic [AW-1:0] wrPtr;
  logic [CW-1:0] count;
  logic          full;
  logic          doPop;
  logic          doPush;

  // Handshake qualification; flush frees the whole buffer so its push always lands.
  always_comb begin
    full         = (count == CW'(DEPTH));
    empty        = (count == '0);
    doPop        = pop && !empty;
    doPush       = push && (!full || doPop);
    pushAccepted = push && (flush || !full || doPop);
    popData      = mem[rdPtr];
  end

  // Storage, pointers and occupancy count.
  always_ff @(posedge clock) begin
    if (!reset) begin
      mem   <= '{default: '0};
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else if (flush) begin
      // A push coinciding with flush becomes the sole entry at slot 0.
      rdPtr <= '0;
      if (push) begin
        mem[0] <= pushData;
        wrPtr  <= AW'(1);
        count  <= CW'(1);
      end else begin
        wrPtr <= '0;
        count <= '0;
      end
    end else begin
      if (doPush) begin
        mem[wrPtr] <= pushData;
        wrPtr      <= wrPtr + AW'(1);
      end
      if (doPop) begin
        rdPtr <= rdPtr + AW'(1);
      end
      case ({doPush, doPop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/arch_event_gen.sv
// ArchEvent producer: encodes commit-time traps, tags them and queues them for the difftest sink.
module arch_event_gen
  import arch_event_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned CAUSE_W = ARCH_EVENT_CAUSE_W,
  parameter int unsigned SEQ_W   = ARCH_EVENT_SEQ_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic               flush,
  input  logic               trap_valid,
  input  logic               trap_is_interrupt,
  input  logic [CAUSE_W-1:0] trap_cause,
  input  logic [63:0]        trap_pc,
  input  logic [31:0]        trap_inst,
  input  logic               trap_has_nmi,
  input  logic               trap_hvictl_inject,
  input  logic               trap_ir_to_hs,
  input  logic               trap_ir_to_vs,
  input  logic [7:0]         coreid,
  arch_event_gen_if.master   evOut,
  output logic               overflow,
  output logic [SEQ_W-1:0]   drop_cnt
);

  logic             pushReq;
  logic             pushOk;
  logic             fifoEmpty;
  logic [SEQ_W-1:0] seqReg;
  arch_event_t      pushData;
  arch_event_t      head;

  // Capture qualification and encoding of the incoming trap (the struct carries a fixed-width seq).
  always_comb begin
    pushReq  = trap_valid && enable;
    pushData = encodeEvent(trap_is_interrupt, 31'(trap_cause), trap_pc, trap_inst,
                           trap_has_nmi, trap_hvictl_inject, trap_ir_to_hs, trap_ir_to_vs,
                           coreid, ARCH_EVENT_SEQ_W'(seqReg));
  end

  arch_event_fifo #(
    .DEPTH(DEPTH)
  ) eventFifo (
    .clock       (clock),
    .reset       (reset),
    .flush       (flush),
    .push        (pushReq),
    .pushData    (pushData),
    .pop         (evOut.out_ready),
    .popData     (head),
    .empty       (fifoEmpty),
    .pushAccepted(pushOk)
  );

  // Sequence tag advances only on accepted pushes; refused pushes feed the sticky drop statistics.
  always_ff @(posedge clock) begin
    if (!reset) begin
      seqReg   <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (pushOk) begin
        seqReg <= seqReg + SEQ_W'(1);
      end
      if (pushReq && !pushOk) begin
        overflow <= 1'b1;
        if (drop_cnt != '1) begin
          drop_cnt <= drop_cnt + SEQ_W'(1);
        end
      end
    end
  end

  // Output channel is a straight view of the FIFO head entry.
  always_comb begin
    evOut.out_valid          = !fifoEmpty;
    evOut.out_interrupt      = head.interrupt;
    evOut.out_exception      = head.exception;
    evOut.out_exception_pc   = head.pc;
    evOut.out_exception_inst = head.inst;
    evOut.out_has_nmi        = head.hasNmi;
    evOut.out_hvictl_inject  = head.hvictlInject;
    evOut.out_ir_to_hs       = head.irToHs;
    evOut.out_ir_to_vs       = head.irToVs;
    evOut.out_coreid         = head.coreid;
    evOut.out_seq            = SEQ_W'(head.seq);
  end

endmodule
